io_bus_arbiter: RTL

//   Shares the 8-bit local bus of the on-board basic I/O block (switches, buttons, LEDs, displays)

---
 rtl/io_bus_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the basic I/O block's 8-bit local bus between CPU (port 0) and debug monitor (port 1).
// Latency: winner latched at the sampling edge, bus driven ACCESS_CYCLES cycles, then a one-cycle ack.
// Backpressure: each requester holds req until its ack; a losing requester waits in IDLE with req held.

module io_bus_arbiter #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       rdwr0_,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       rdwr1_,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata1,
  output logic [7:0] io_addr,
  output logic [7:0] io_data_in,
  output logic       io_rdwr_,
  input  logic [7:0] io_data_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last_grant, last_grant_nxt;
  logic       gnt, gnt_nxt;          // port owning the current transaction
  logic       winner;
  logic [7:0] io_addr_nxt, io_data_in_nxt;
  logic       io_rdwr_nxt;
  logic       ack0_nxt, ack1_nxt;
  logic [7:0] rdata0_nxt, rdata1_nxt;
  logic       busy_nxt;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    gnt_nxt        = gnt;
    winner         = 1'b0;
    io_addr_nxt    = io_addr;
    io_data_in_nxt = io_data_in;
    io_rdwr_nxt    = io_rdwr_;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes next.
          winner         = (req0 && req1) ? ~last_grant : req1;
          gnt_nxt        = winner;
          last_grant_nxt = winner;
          io_addr_nxt    = winner ? addr1  : addr0;
          io_data_in_nxt = winner ? wdata1 : wdata0;
          io_rdwr_nxt    = winner ? rdwr1_ : rdwr0_;
          cnt_nxt        = CNT_LOAD;
          state_nxt      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          // io_rdwr_ still holds the latched direction: high means this is a read.
          if (io_rdwr_) begin
            if (gnt) rdata1_nxt = io_data_out;
            else     rdata0_nxt = io_data_out;
          end
          io_rdwr_nxt = 1'b1;
          ack0_nxt    = ~gnt;
          ack1_nxt    = gnt;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        io_rdwr_nxt = 1'b1;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset aborts any transaction and releases the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      io_addr    <= 8'h00;
      io_data_in <= 8'h00;
      io_rdwr_   <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= 8'h00;
      rdata1     <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
      io_addr    <= io_addr_nxt;
      io_data_in <= io_data_in_nxt;
      io_rdwr_   <= io_rdwr_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
